// File: rtl/iob_axi_bridge_pkg.sv
// Shared types and constants for the IOb-to-AXI4 master bridge.
// FSM encoding, AXI burst/response codes and the beat-size helper.
package iob_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4
    } bridge_state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/iob_axi_bridge_wr_ctrl.sv
// Write-side handshake tracker: AW and W complete independently,
// each valid drops the cycle after its own handshake.
module iob_axi_bridge_wr_ctrl (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cke_i,
    input  logic active_i,
    input  logic awready_i,
    input  logic wready_i,
    output logic awvalid_o,
    output logic wvalid_o,
    output logic done_o
);
    import iob_axi_bridge_pkg::*;

    logic aw_done;
    logic w_done;
    logic aw_hs;
    logic w_hs;

    assign awvalid_o = active_i & ~aw_done;
    assign wvalid_o  = active_i & ~w_done;
    assign aw_hs     = awvalid_o & awready_i;
    assign w_hs      = wvalid_o & wready_i;

    // Done as soon as the last outstanding handshake is happening.
    assign done_o = active_i & (aw_done | aw_hs) & (w_done | w_hs);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (cke_i) begin
            if (!active_i) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_axi_master_bridge.sv
// Converts single IOb requests into single-beat AXI4 transactions,
// one outstanding transaction at a time.
module iob_axi_master_bridge #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int AXI_ID_W = 4,
    parameter int AXI_ID   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cke_i,
    input  logic                  iob_avalid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic                  iob_ready_o,
    output logic                  iob_rvalid_o,
    output logic [DATA_W-1:0]     iob_rdata_o,
    output logic                  err_o,
    output logic [AXI_ID_W-1:0]   axi_awid_o,
    output logic [ADDR_W-1:0]     axi_awaddr_o,
    output logic [7:0]            axi_awlen_o,
    output logic [2:0]            axi_awsize_o,
    output logic [1:0]            axi_awburst_o,
    output logic                  axi_awvalid_o,
    input  logic                  axi_awready_i,
    output logic [DATA_W-1:0]     axi_wdata_o,
    output logic [DATA_W/8-1:0]   axi_wstrb_o,
    output logic                  axi_wlast_o,
    output logic                  axi_wvalid_o,
    input  logic                  axi_wready_i,
    input  logic [AXI_ID_W-1:0]   axi_bid_i,
    input  logic [1:0]            axi_bresp_i,
    input  logic                  axi_bvalid_i,
    output logic                  axi_bready_o,
    output logic [AXI_ID_W-1:0]   axi_arid_o,
    output logic [ADDR_W-1:0]     axi_araddr_o,
    output logic [7:0]            axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    input  logic [AXI_ID_W-1:0]   axi_rid_i,
    input  logic [DATA_W-1:0]     axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rlast_i,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o
);
    import iob_axi_bridge_pkg::*;

    localparam int LSB = $clog2(DATA_W / 8);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("iob_axi_master_bridge: DATA_W must be 32 or 64");
    end

    bridge_state_t state;
    bridge_state_t state_nxt;

    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rvalid_q;
    logic                err_q;

    logic wr_active;
    logic wr_done;
    logic accept;
    logic b_hs;
    logic r_hs;

    // Responses carry no information we need beyond the error bit.
    logic unused_rsp;
    assign unused_rsp = ^{axi_bid_i, axi_rid_i, axi_rlast_i,
                          axi_bresp_i[0], axi_rresp_i[0]};

    assign accept = (state == ST_IDLE) & iob_avalid_i;
    assign b_hs   = (state == ST_WR_RESP) & axi_bvalid_i;
    assign r_hs   = (state == ST_RD_DATA) & axi_rvalid_i;

    iob_axi_bridge_wr_ctrl u_wr_ctrl (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cke_i     (cke_i),
        .active_i  (wr_active),
        .awready_i (axi_awready_i),
        .wready_i  (axi_wready_i),
        .awvalid_o (axi_awvalid_o),
        .wvalid_o  (axi_wvalid_o),
        .done_o    (wr_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else if (cke_i) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (iob_avalid_i)
                    state_nxt = (|iob_wstrb_i) ? ST_WR : ST_RD_ADDR;
            ST_WR:
                if (wr_done) state_nxt = ST_WR_RESP;
            ST_WR_RESP:
                if (axi_bvalid_i) state_nxt = ST_IDLE;
            ST_RD_ADDR:
                if (axi_arready_i) state_nxt = ST_RD_DATA;
            ST_RD_DATA:
                if (axi_rvalid_i) state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        iob_ready_o   = 1'b0;
        wr_active     = 1'b0;
        axi_bready_o  = 1'b0;
        axi_arvalid_o = 1'b0;
        axi_rready_o  = 1'b0;
        unique case (1'b1)
            state == ST_IDLE:    iob_ready_o   = 1'b1;
            state == ST_WR:      wr_active     = 1'b1;
            state == ST_WR_RESP: axi_bready_o  = 1'b1;
            state == ST_RD_ADDR: axi_arvalid_o = 1'b1;
            state == ST_RD_DATA: axi_rready_o  = 1'b1;
            default: ;
        endcase
    end

    // Request latch, read capture and the one-cycle response pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (cke_i) begin
            rvalid_q <= r_hs;
            err_q    <= (b_hs & axi_bresp_i[1]) | (r_hs & axi_rresp_i[1]);
            if (accept) begin
                addr_q  <= {iob_addr_i[ADDR_W-1:LSB], {LSB{1'b0}}};
                wdata_q <= iob_wdata_i;
                wstrb_q <= iob_wstrb_i;
            end
            if (r_hs) rdata_q <= axi_rdata_i;
        end
    end

    assign iob_rvalid_o = rvalid_q;
    assign iob_rdata_o  = rdata_q;
    assign err_o        = err_q;

    assign axi_awid_o    = AXI_ID_W'(AXI_ID);
    assign axi_awaddr_o  = addr_q;
    assign axi_awlen_o   = 8'd0;
    assign axi_awsize_o  = axi_size(DATA_W);
    assign axi_awburst_o = AXI_BURST_INCR;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = wstrb_q;
    assign axi_wlast_o   = 1'b1;

    assign axi_arid_o    = AXI_ID_W'(AXI_ID);
    assign axi_araddr_o  = addr_q;
    assign axi_arlen_o   = 8'd0;
    assign axi_arsize_o  = axi_size(DATA_W);
    assign axi_arburst_o = AXI_BURST_INCR;

endmodule

// File: tb/tb_iob_axi_master_bridge.sv
// Testbench for iob_axi_master_bridge with a small AXI memory slave.
// Directed vector table, corner sequences and a randomized model check.
module tb_iob_axi_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cke;
    logic        iob_avalid;
    logic [31:0] iob_addr;
    logic [31:0] iob_wdata;
    logic [3:0]  iob_wstrb;
    logic        iob_ready;
    logic        iob_rvalid;
    logic [31:0] iob_rdata;
    logic        err;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    assign bid   = 4'd0;
    assign rid   = 4'd0;
    assign rlast = 1'b1;

    always #5 clk = ~clk;

    iob_axi_master_bridge dut (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .iob_avalid_i(iob_avalid), .iob_addr_i(iob_addr),
        .iob_wdata_i(iob_wdata), .iob_wstrb_i(iob_wstrb),
        .iob_ready_o(iob_ready), .iob_rvalid_o(iob_rvalid),
        .iob_rdata_o(iob_rdata), .err_o(err),
        .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen),
        .axi_awsize_o(awsize), .axi_awburst_o(awburst),
        .axi_awvalid_o(awvalid), .axi_awready_i(awready),
        .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
        .axi_wvalid_o(wvalid), .axi_wready_i(wready),
        .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid),
        .axi_bready_o(bready),
        .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen),
        .axi_arsize_o(arsize), .axi_arburst_o(arburst),
        .axi_arvalid_o(arvalid), .axi_arready_i(arready),
        .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp),
        .axi_rlast_i(rlast), .axi_rvalid_i(rvalid), .axi_rready_o(rready)
    );

    // ---------------- AXI memory slave (shares rst and cke) ----------------
    int aw_wait = 0, w_wait = 0, ar_wait = 0;
    bit b_err = 0, r_err = 0, r_hold = 0;

    logic [31:0] mem [0:255];
    int aw_cnt, w_cnt, ar_cnt;
    logic got_aw, got_w;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] c_addr, c_data, c_new;
    logic [3:0]  c_strb;
    logic aw_hs, w_hs, ar_hs;
    int n_aw = 0, n_w = 0, n_commit = 0, n_awv = 0, n_wv = 0;
    logic [31:0] cap_awaddr, cap_araddr;
    logic [7:0]  cap_awlen, cap_arlen;
    logic [2:0]  cap_awsize, cap_arsize;
    logic [1:0]  cap_awburst, cap_arburst;
    logic [3:0]  cap_awid, cap_wstrb;
    logic        cap_wlast;

    function automatic logic [31:0] slave_merge(input logic [31:0] o,
                                                input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always_comb begin
        awready = cke & awvalid & (aw_cnt >= aw_wait);
        wready  = cke & wvalid & (w_cnt >= w_wait);
        arready = cke & arvalid & (ar_cnt >= ar_wait);
        aw_hs   = awvalid & awready;
        w_hs    = wvalid & wready;
        ar_hs   = arvalid & arready;
        c_addr  = got_aw ? s_awaddr : awaddr;
        c_data  = got_w ? s_wdata : wdata;
        c_strb  = got_w ? s_wstrb : wstrb;
        c_new   = slave_merge(mem[c_addr[9:2]], c_data, c_strb);
    end

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (cke) begin
            n_awv  <= n_awv + int'(awvalid);
            n_wv   <= n_wv + int'(wvalid);
            aw_cnt <= (awvalid && !aw_hs) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !w_hs) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !ar_hs) ? ar_cnt + 1 : 0;
            if (aw_hs) begin
                got_aw <= 1'b1; s_awaddr <= awaddr; n_aw <= n_aw + 1;
                cap_awaddr <= awaddr; cap_awlen <= awlen;
                cap_awsize <= awsize; cap_awburst <= awburst;
                cap_awid <= awid;
            end
            if (w_hs) begin
                got_w <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb;
                n_w <= n_w + 1; cap_wlast <= wlast; cap_wstrb <= wstrb;
            end
            if ((got_aw || aw_hs) && (got_w || w_hs) && !bvalid) begin
                mem[c_addr[9:2]] <= c_new;
                n_commit <= n_commit + 1;
                bvalid <= 1'b1;
                bresp  <= b_err ? 2'b10 : 2'b00;
                got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (ar_hs) begin
                cap_araddr <= araddr; cap_arlen <= arlen;
                cap_arsize <= arsize; cap_arburst <= arburst;
                if (!r_hold) begin
                    rvalid <= 1'b1;
                    rdata  <= mem[araddr[9:2]];
                    rresp  <= r_err ? 2'b10 : 2'b00;
                end
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One IOb transaction; called and returns at a negedge with the bridge idle.
    task automatic iob_txn(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd,
                           output int lat, output int nrv,
                           output int nerr, output int nboth);
        int t = 0;
        iob_avalid = 1'b1; iob_addr = a; iob_wdata = d; iob_wstrb = s;
        while (!iob_ready && t < 200) begin
            @(negedge clk); t++;
        end
        @(negedge clk);
        iob_avalid = 1'b0; iob_wstrb = 4'h0;
        lat = 1; nrv = 0; nerr = 0; nboth = 0; rd = '0;
        while (!iob_ready && lat < 200) begin
            nrv += int'(iob_rvalid); nerr += int'(err);
            @(negedge clk); lat++;
        end
        for (int k = 0; k < 2; k++) begin
            nrv += int'(iob_rvalid); nerr += int'(err);
            nboth += int'(iob_rvalid & err);
            if (iob_rvalid) rd = iob_rdata;
            if (k == 0) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_ax;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] ref_mem [0:255];

    function automatic logic [31:0] model_write(input logic [31:0] o,
                                                input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
        return (o & ~m) | (d & m);
    endfunction

    initial begin
        logic [31:0] rd, a, d;
        logic [3:0]  s;
        logic [63:0] snap;
        int lat, nrv, nerr, nboth, c0, c1, c2, c3, c4;
        bit is_rd, e;

        vecs[0] = '{32'h100, 32'hDEADBEEF, 4'hF, 32'h100, 32'h0};
        vecs[1] = '{32'h100, 32'h0,        4'h0, 32'h100, 32'hDEADBEEF};
        vecs[2] = '{32'h100, 32'h11223344, 4'hF, 32'h100, 32'h0};
        vecs[3] = '{32'h103, 32'h00AA0000, 4'h4, 32'h100, 32'h0};
        vecs[4] = '{32'h101, 32'h0,        4'h0, 32'h100, 32'h11AA3344};
        vecs[5] = '{32'h206, 32'hCAFEF00D, 4'h3, 32'h204, 32'h0};
        vecs[6] = '{32'h204, 32'h0,        4'h0, 32'h204, 32'h0000F00D};
        vecs[7] = '{32'h300, 32'h0,        4'h0, 32'h300, 32'h0};

        rst = 1'b1; cke = 1'b1; iob_avalid = 1'b0;
        iob_addr = '0; iob_wdata = '0; iob_wstrb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", iob_ready, 1);
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        chk("rst_rvalid_err", {iob_rvalid, err}, 0);
        chk("rst_rdata", iob_rdata, 0);

        foreach (vecs[i]) begin
            is_rd = (vecs[i].wstrb == 4'h0);
            iob_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                    rd, lat, nrv, nerr, nboth);
            chk($sformatf("vec%0d_latency", i), lat, 3);
            chk($sformatf("vec%0d_rvalid_pulses", i), nrv, is_rd);
            chk($sformatf("vec%0d_err", i), nerr, 0);
            chk($sformatf("vec%0d_axaddr", i),
                is_rd ? cap_araddr : cap_awaddr, vecs[i].exp_ax);
            if (is_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            if (i == 0)
                chk("aw_const", {cap_awlen, cap_awsize, cap_awburst,
                                 cap_awid, cap_wlast, cap_wstrb},
                    {8'd0, 3'd2, 2'b01, 4'd0, 1'b1, 4'hF});
            if (i == 1)
                chk("ar_const", {cap_arlen, cap_arsize, cap_arburst},
                    {8'd0, 3'd2, 2'b01});
        end

        // Skewed handshakes: AW stalls, W goes through at once.
        aw_wait = 4; w_wait = 0;
        c0 = n_awv; c1 = n_wv; c2 = n_aw; c3 = n_w; c4 = n_commit;
        iob_txn(32'h120, 32'hA5A55A5A, 4'hF, rd, lat, nrv, nerr, nboth);
        chk("skew_awvalid_cycles", n_awv - c0, 5);
        chk("skew_wvalid_cycles", n_wv - c1, 1);
        chk("skew_single_aw_w", {16'(n_aw - c2), 16'(n_w - c3)}, {16'd1, 16'd1});
        chk("skew_single_commit", n_commit - c4, 1);
        chk("skew_latency", lat, 7);
        aw_wait = 0;
        iob_txn(32'h120, 32'h0, 4'h0, rd, lat, nrv, nerr, nboth);
        chk("skew_readback", rd, 32'hA5A55A5A);

        // Error responses.
        r_err = 1;
        iob_txn(32'h100, 32'h0, 4'h0, rd, lat, nrv, nerr, nboth);
        r_err = 0;
        chk("rerr_pulses", {8'(nrv), 8'(nerr), 8'(nboth)}, {8'd1, 8'd1, 8'd1});
        chk("rerr_latency", lat, 3);
        b_err = 1;
        iob_txn(32'h140, 32'h01020304, 4'hF, rd, lat, nrv, nerr, nboth);
        b_err = 0;
        chk("berr_pulses", {8'(nrv), 8'(nerr)}, {8'd0, 8'd1});
        chk("berr_latency", lat, 3);

        // Clock enable low for 4 cycles while in WR.
        aw_wait = 2; w_wait = 1;
        iob_avalid = 1'b1; iob_addr = 32'h144;
        iob_wdata = 32'h55667788; iob_wstrb = 4'hF;
        @(negedge clk);
        iob_avalid = 1'b0; iob_wstrb = 4'h0; cke = 1'b0;
        snap = {awvalid, wvalid, bready, iob_ready, awaddr, wdata[23:0]};
        chk("cke_in_wr", {awvalid, wvalid, iob_ready}, 3'b110);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("cke_hold%0d", k),
                {awvalid, wvalid, bready, iob_ready, awaddr, wdata[23:0]},
                snap);
        end
        cke = 1'b1;
        lat = 0;
        while (!iob_ready && lat < 200) begin
            @(negedge clk); lat++;
        end
        chk("cke_resume_latency", lat, 4);
        aw_wait = 0; w_wait = 0;
        iob_txn(32'h144, 32'h0, 4'h0, rd, lat, nrv, nerr, nboth);
        chk("cke_readback", rd, 32'h55667788);

        // Reset while waiting in RD_DATA.
        r_hold = 1;
        iob_avalid = 1'b1; iob_addr = 32'h180; iob_wstrb = 4'h0;
        @(negedge clk);
        iob_avalid = 1'b0;
        @(negedge clk);
        chk("rdata_state_rready", {rready, iob_ready}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; r_hold = 0;
        chk("midrst_ready", iob_ready, 1);
        chk("midrst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        chk("midrst_outs", {iob_rvalid, err, iob_rdata}, 0);

        // Randomized traffic against a word-array memory model.
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        for (int n = 0; n < 200; n++) begin
            a = 32'($urandom_range(0, 255));
            is_rd = bit'($urandom_range(0, 1));
            s = is_rd ? 4'h0 : 4'($urandom_range(1, 15));
            d = $urandom;
            e = ($urandom_range(0, 7) == 0);
            aw_wait = $urandom_range(0, 3);
            w_wait = $urandom_range(0, 3);
            ar_wait = $urandom_range(0, 3);
            b_err = e & !is_rd; r_err = e & is_rd;
            iob_txn(a, d, s, rd, lat, nrv, nerr, nboth);
            chk($sformatf("rnd%0d_done", n), lat < 200, 1);
            chk($sformatf("rnd%0d_rvalid", n), nrv, is_rd);
            chk($sformatf("rnd%0d_err", n), nerr, e);
            chk($sformatf("rnd%0d_axaddr", n),
                is_rd ? cap_araddr : cap_awaddr, {a[31:2], 2'b00});
            if (is_rd)
                chk($sformatf("rnd%0d_rdata", n), rd, ref_mem[a[9:2]]);
            else
                ref_mem[a[9:2]] = model_write(ref_mem[a[9:2]], d, s);
        end
        b_err = 0; r_err = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
